button_debouncer: RTL and testbench

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

---
 rtl/button_debouncer.sv | 118 +++++++++++
 tb/tb_button_debouncer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// Debounces a raw mechanical button: 2-flop synchronizer, four-state qualification FSM,
// and registered level/press/release/busy outputs.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 20
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic busy
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    logic          sync_meta;
    logic          btn_sync;
    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          level_next;
    logic          press_next;
    logic          release_next;
    logic          busy_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= 1'b0;
            btn_sync  <= 1'b0;
        end else begin
            sync_meta <= btn_raw;
            btn_sync  <= sync_meta;
        end
    end

    // Outputs are registered from the next-state decode so they change on the
    // same edge as the state they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            btn_level     <= level_next;
            press_pulse   <= press_next;
            release_pulse <= release_next;
            busy          <= busy_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (btn_sync) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_sync) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            PRESSED: begin
                if (!btn_sync) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn_sync) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        level_next   = (state_next == PRESSED) || (state_next == RELEASE_WAIT);
        busy_next    = (state_next == PRESS_WAIT) || (state_next == RELEASE_WAIT);
        press_next   = (state == PRESS_WAIT) && (state_next == PRESSED);
        release_next = (state == RELEASE_WAIT) && (state_next == IDLE);
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4: latency, bounce rejection,
// glitch filtering, async reset abort and a downstream 4-bit press counter.
module tb_button_debouncer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       btn_raw = 1'b0;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       busy;
    logic [3:0] ds_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int press_cnt = 0;
    int rel_cnt   = 0;

    button_debouncer #(.DEBOUNCE_CYCLES(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .btn_raw       (btn_raw),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Downstream counter enabled by press_pulse.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) ds_cnt <= 4'd0;
        else if (press_pulse) ds_cnt <= ds_cnt + 4'd1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        if (press_pulse) press_cnt++;
        if (release_pulse) rel_cnt++;
    end

    always @(negedge clk) begin
        if (press_pulse || release_pulse)
            chk("no_overlap", int'(press_pulse & release_pulse), 0);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_outs(input string tag, input int lvl, input int pp, input int rp, input int bz);
        chk({tag, ".level"},   int'(btn_level),     lvl);
        chk({tag, ".press"},   int'(press_pulse),   pp);
        chk({tag, ".release"}, int'(release_pulse), rp);
        chk({tag, ".busy"},    int'(busy),          bz);
    endtask

    initial begin
        int   base_p;
        int   base_r;
        logic seen_level;
        logic seen_busy;

        step(2);
        chk_outs("reset", 0, 0, 0, 0);
        reset_n = 1'b1;
        step(2);

        // Clean press: edge 1 samples high, pulse after edge 7.
        btn_raw = 1'b1;
        step(2);
        chk_outs("press_e2", 0, 0, 0, 0);
        step(1);
        chk_outs("press_e3", 0, 0, 0, 1);
        step(3);
        chk_outs("press_e6", 0, 0, 0, 1);
        step(1);
        chk_outs("press_e7", 1, 1, 0, 0);
        step(1);
        chk_outs("press_e8", 1, 0, 0, 0);
        step(4);
        chk("press_count1", press_cnt, 1);

        // Clean release, symmetric latency.
        btn_raw = 1'b0;
        step(6);
        chk_outs("rel_e6", 1, 0, 0, 1);
        step(1);
        chk_outs("rel_e7", 0, 0, 1, 0);
        step(1);
        chk_outs("rel_e8", 0, 0, 0, 0);
        step(2);
        chk("rel_count1", rel_cnt, 1);

        // Bounce 1,0,1,0 every two cycles, then low.
        seen_level = 1'b0;
        seen_busy  = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (i < 8) btn_raw = (i % 4) < 2;
            else btn_raw = 1'b0;
            step(1);
            seen_level |= btn_level;
            seen_busy  |= busy;
        end
        chk("bounce_level", int'(seen_level), 0);
        chk("bounce_busy_seen", int'(seen_busy), 1);
        chk("bounce_press_count", press_cnt, 1);
        chk_outs("bounce_end", 0, 0, 0, 0);

        // Press, 2-cycle release glitch mid-hold, then a real release.
        btn_raw = 1'b1;
        step(10);
        chk("glitch_press_count", press_cnt, 2);
        btn_raw = 1'b0;
        step(2);
        btn_raw = 1'b1;
        step(10);
        chk("glitch_rel_count", rel_cnt, 1);
        chk("glitch_level", int'(btn_level), 1);
        chk("glitch_press_count2", press_cnt, 2);
        btn_raw = 1'b0;
        step(10);
        chk("final_rel_count", rel_cnt, 2);
        chk("final_level", int'(btn_level), 0);
        chk("final_press_count", press_cnt, 2);

        // Reset during PRESS_WAIT, then during the press pulse, button held high.
        btn_raw = 1'b1;
        step(4);
        chk("rst_pw_busy", int'(busy), 1);
        #2 reset_n = 1'b0;
        #1 chk_outs("rst_pw_async", 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        base_p = press_cnt;
        step(6);
        chk_outs("rst_pw_e6", 0, 0, 0, 1);
        step(1);
        chk_outs("rst_pw_e7", 1, 1, 0, 0);
        #2 reset_n = 1'b0;
        #1 chk_outs("rst_pulse_async", 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        step(7);
        chk_outs("rst_pulse_e7", 1, 1, 0, 0);
        step(4);
        chk("rst_single_press", press_cnt - base_p, 1);

        btn_raw = 1'b0;
        step(10);
        chk("rst_release_level", int'(btn_level), 0);

        // Integration: 17 presses into the 4-bit downstream counter.
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        chk("ds_reset", int'(ds_cnt), 0);
        base_p = press_cnt;
        base_r = rel_cnt;
        for (int i = 0; i < 17; i++) begin
            btn_raw = 1'b1;
            step(8);
            btn_raw = 1'b0;
            step(8);
        end
        step(2);
        chk("int_press_count", press_cnt - base_p, 17);
        chk("int_rel_count", rel_cnt - base_r, 17);
        chk("int_ds_cnt", int'(ds_cnt), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
